// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light monitor: light bus values, phase codes,
// error codes and checker FSM states, plus small decode helpers.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b010;
    localparam logic [2:0] LIGHT_YELLOW = 3'b001;

    typedef enum logic [1:0] {
        PHASE_NONE   = 2'b00,
        PHASE_RED    = 2'b01,
        PHASE_GREEN  = 2'b10,
        PHASE_YELLOW = 2'b11
    } phase_t;

    localparam logic [2:0] ERR_NONE        = 3'b000;
    localparam logic [2:0] ERR_ILLEGAL_ENC = 3'b001;
    localparam logic [2:0] ERR_BAD_SEQ     = 3'b010;
    localparam logic [2:0] ERR_SHORT       = 3'b011;
    localparam logic [2:0] ERR_LONG        = 3'b100;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'b00,
        ST_RED    = 2'b01,
        ST_GREEN  = 2'b10,
        ST_YELLOW = 2'b11
    } state_t;

    function automatic logic is_onehot(input logic [2:0] l);
        return (l == LIGHT_RED) || (l == LIGHT_GREEN) || (l == LIGHT_YELLOW);
    endfunction

    function automatic phase_t decode_phase(input logic [2:0] l);
        case (l)
            LIGHT_RED:    return PHASE_RED;
            LIGHT_GREEN:  return PHASE_GREEN;
            LIGHT_YELLOW: return PHASE_YELLOW;
            default:      return PHASE_NONE;
        endcase
    endfunction

    // Legal successor in the R -> G -> Y -> R ring; 000 for anything else.
    function automatic logic [2:0] next_light(input logic [2:0] l);
        case (l)
            LIGHT_RED:    return LIGHT_GREEN;
            LIGHT_GREEN:  return LIGHT_YELLOW;
            LIGHT_YELLOW: return LIGHT_RED;
            default:      return 3'b000;
        endcase
    endfunction

    function automatic state_t light_state(input logic [2:0] l);
        case (l)
            LIGHT_RED:    return ST_RED;
            LIGHT_GREEN:  return ST_GREEN;
            LIGHT_YELLOW: return ST_YELLOW;
            default:      return ST_SYNC;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light bus plus monitor status signals; master = controller/bench side,
// slave = the monitor.
interface traffic_light_monitor_if;
    logic [2:0]  light;
    logic        clr_err;
    logic [1:0]  phase;
    logic        locked;
    logic        err_valid;
    logic [2:0]  err_code;
    logic        err_sticky;
    logic [15:0] cycles;
    logic [7:0]  err_count;

    modport master (
        output light, clr_err,
        input  phase, locked, err_valid, err_code, err_sticky, cycles, err_count
    );

    modport slave (
        input  light, clr_err,
        output phase, locked, err_valid, err_code, err_sticky, cycles, err_count
    );
endinterface

// File: rtl/traffic_light_monitor_dwell.sv
// Holds the previous light sample, flags a new value and counts how many
// consecutive edges the held value has been seen (saturating).
module tl_dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       light,
    output logic [2:0]       light_q,
    output logic             new_val,
    output logic [CNT_W-1:0] dwell
);

    logic [2:0]       light_q_reg;
    logic [CNT_W-1:0] dwell_reg, dwell_next;
    logic [2:0]       diff;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_diff
            assign diff[gi] = light[gi] ^ light_q_reg[gi];
        end
    endgenerate

    assign new_val = |diff;

    always_comb begin
        dwell_next = dwell_reg;
        if (new_val)
            dwell_next = CNT_W'(1);
        else if (dwell_reg != {CNT_W{1'b1}})
            dwell_next = dwell_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            light_q_reg <= 3'b000;
            dwell_reg   <= '0;
        end else begin
            light_q_reg <= light;
            dwell_reg   <= dwell_next;
        end
    end

    assign light_q = light_q_reg;
    assign dwell   = dwell_reg;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive sequence/timing checker for the one-hot traffic light bus.
// Optional saturating error counter enabled by defining TLM_ERR_CNT_EN.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int RED_TIME    = 20,
    parameter int GREEN_TIME  = 15,
    parameter int YELLOW_TIME = 5,
    parameter int CNT_W       = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    traffic_light_monitor_if.slave bus
);

    localparam logic [CNT_W-1:0] RED_E    = CNT_W'(RED_TIME + 1);
    localparam logic [CNT_W-1:0] GREEN_E  = CNT_W'(GREEN_TIME + 1);
    localparam logic [CNT_W-1:0] YELLOW_E = CNT_W'(YELLOW_TIME + 1);

    logic [2:0]       light_q;
    logic             new_val;
    logic [CNT_W-1:0] dwell;

    tl_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk     (clk),
        .rst_n   (rst_n),
        .light   (bus.light),
        .light_q (light_q),
        .new_val (new_val),
        .dwell   (dwell)
    );

    state_t           state_reg, state_next;
    phase_t           phase_reg, phase_next;
    logic [2:0]       err_next;
    logic             cycle_done;
    logic [CNT_W-1:0] exp_time;
    logic [2:0]       exp_light;
    logic             err_valid_reg, err_valid_next;
    logic [2:0]       err_code_reg, err_code_next;
    logic             err_sticky_reg, err_sticky_next;
    logic [15:0]      cycles_reg, cycles_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_SYNC;
            phase_reg      <= PHASE_NONE;
            err_valid_reg  <= 1'b0;
            err_code_reg   <= ERR_NONE;
            err_sticky_reg <= 1'b0;
            cycles_reg     <= 16'h0000;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            err_valid_reg  <= err_valid_next;
            err_code_reg   <= err_code_next;
            err_sticky_reg <= err_sticky_next;
            cycles_reg     <= cycles_next;
        end
    end

    // Error priority falls out of the if-chain order: ILLEGAL_ENC, BAD_SEQ, SHORT.
    always_comb begin
        state_next = state_reg;
        err_next   = ERR_NONE;
        cycle_done = 1'b0;
        exp_time   = RED_E;
        exp_light  = LIGHT_GREEN;
        case (state_reg)
            ST_GREEN: begin
                exp_time  = GREEN_E;
                exp_light = LIGHT_YELLOW;
            end
            ST_YELLOW: begin
                exp_time  = YELLOW_E;
                exp_light = LIGHT_RED;
            end
            default: ;
        endcase

        if (new_val && !is_onehot(bus.light)) begin
            err_next = ERR_ILLEGAL_ENC;
        end else if (state_reg == ST_SYNC) begin
            // Dwell of the phase we synchronise on is not checked.
            if (new_val && is_onehot(light_q) && bus.light == next_light(light_q))
                state_next = light_state(bus.light);
        end else if (new_val) begin
            if (bus.light != exp_light) begin
                err_next = ERR_BAD_SEQ;
            end else if (dwell < exp_time) begin
                err_next = ERR_SHORT;
            end else begin
                state_next = light_state(bus.light);
                cycle_done = (state_reg == ST_YELLOW);
            end
        end else if (dwell == exp_time) begin
            err_next = ERR_LONG;
        end

        if (err_next != ERR_NONE)
            state_next = ST_SYNC;
    end

    always_comb begin
        phase_next      = decode_phase(bus.light);
        err_valid_next  = (err_next != ERR_NONE);
        err_code_next   = err_valid_next ? err_next : err_code_reg;
        err_sticky_next = err_valid_next | (err_sticky_reg & ~bus.clr_err);
        cycles_next     = cycles_reg + 16'(cycle_done);
    end

    assign bus.phase      = phase_reg;
    assign bus.locked     = (state_reg != ST_SYNC);
    assign bus.err_valid  = err_valid_reg;
    assign bus.err_code   = err_code_reg;
    assign bus.err_sticky = err_sticky_reg;
    assign bus.cycles     = cycles_reg;

`ifdef TLM_ERR_CNT_EN
    logic [7:0] err_count_reg, err_count_next;

    // A clear and a new error on the same edge leaves a count of one.
    always_comb begin
        err_count_next = bus.clr_err ? 8'h00 : err_count_reg;
        if (err_valid_next && err_count_next != 8'hFF)
            err_count_next = err_count_next + 8'h01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count_reg <= 8'h00;
        else
            err_count_reg <= err_count_next;
    end

    assign bus.err_count = err_count_reg;
`else
    assign bus.err_count = 8'h00;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed scenarios plus random phase sequences, every edge compared against
// a rule-level reference model of the monitor.
module tb_traffic_light_monitor;

    localparam int RED_TIME    = 20;
    localparam int GREEN_TIME  = 15;
    localparam int YELLOW_TIME = 5;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    traffic_light_monitor_if bus_if();

    traffic_light_monitor #(
        .RED_TIME    (RED_TIME),
        .GREEN_TIME  (GREEN_TIME),
        .YELLOW_TIME (YELLOW_TIME),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int pulses;
    int pulse_at;
    int seg_idx;

    // Phase ring and legal phase lengths, indexed by ring position.
    logic [2:0] ring [3] = '{R, G, Y};
    int         dur_tab [3] = '{RED_TIME + 1, GREEN_TIME + 1, YELLOW_TIME + 1};

    logic [2:0] m_prev;
    int         m_run;
    bit         m_locked;
    int         m_code;
    bit         m_sticky;
    int         m_cycles;
    int         m_cnt;
    bit         m_valid;
    int         m_phase;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pos(input logic [2:0] v);
        for (int i = 0; i < 3; i++)
            if (ring[i] == v) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_prev   = 3'b000;
        m_run    = 0;
        m_locked = 0;
        m_code   = 0;
        m_sticky = 0;
        m_cycles = 0;
        m_cnt    = 0;
        m_valid  = 0;
        m_phase  = 0;
    endfunction

    function automatic void model_step(input logic [2:0] v, input bit clr);
        int  e   = 0;
        bit  chg = (v != m_prev);
        int  p   = pos(m_prev);
        if (chg && pos(v) < 0)
            e = 1;
        else if (!m_locked) begin
            if (chg && p >= 0 && v == ring[(p + 1) % 3]) m_locked = 1;
        end else if (chg) begin
            if (v != ring[(p + 1) % 3])   e = 2;
            else if (m_run < dur_tab[p])  e = 3;
            else if (p == 2)              m_cycles = (m_cycles + 1) % 65536;
        end else if (m_run + 1 == dur_tab[p] + 1)
            e = 4;
        if (clr) begin
            m_sticky = 0;
            m_cnt    = 0;
        end
        m_valid = (e != 0);
        if (e != 0) begin
            m_locked = 0;
            m_code   = e;
            m_sticky = 1;
            if (m_cnt < 255) m_cnt++;
        end
        m_phase = pos(v) + 1;
        m_run   = chg ? 1 : ((m_run < 255) ? m_run + 1 : 255);
        m_prev  = v;
    endfunction

    task automatic compare_all();
        int exp_cnt;
`ifdef TLM_ERR_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        chk("phase",      32'(bus_if.phase),      32'(m_phase));
        chk("locked",     32'(bus_if.locked),     32'(m_locked));
        chk("err_valid",  32'(bus_if.err_valid),  32'(m_valid));
        chk("err_code",   32'(bus_if.err_code),   32'(m_code));
        chk("err_sticky", 32'(bus_if.err_sticky), 32'(m_sticky));
        chk("cycles",     32'(bus_if.cycles),     32'(m_cycles));
        chk("err_count",  32'(bus_if.err_count),  32'(exp_cnt));
    endtask

    task automatic cyc(input logic [2:0] v, input bit clr);
        bus_if.light   = v;
        bus_if.clr_err = clr;
        @(posedge clk);
        model_step(v, clr);
        #1;
        compare_all();
        seg_idx++;
        if (bus_if.err_valid === 1'b1) begin
            pulses++;
            pulse_at = seg_idx;
        end
    endtask

    task automatic run(input logic [2:0] v, input int n, input bit rnd_clr);
        seg_idx = 0;
        for (int i = 0; i < n; i++)
            cyc(v, rnd_clr ? ($urandom_range(0, 15) == 0) : 1'b0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] cur, v;
        logic [2:0] bad_vals [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        int k, n, off;

        bus_if.light   = 3'b000;
        bus_if.clr_err = 1'b0;
        model_reset();
        #2;
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1) clean cycle after reset
        pulses = 0;
        run(R, 21, 0);
        chk("t1_unlocked_in_first_red", 32'(bus_if.locked), 32'd0);
        cyc(G, 0);
        chk("t1_locked_on_r2g", 32'(bus_if.locked), 32'd1);
        run(G, 15, 0);
        run(Y, 6, 0);
        run(R, 21, 0);
        chk("t1_no_pulses", 32'(pulses), 32'd0);
        chk("t1_cycles", 32'(bus_if.cycles), 32'd1);

        // 2) short green
        run(G, 15, 0);
        cyc(Y, 0);
        chk("t2_valid", 32'(bus_if.err_valid), 32'd1);
        chk("t2_code_short", 32'(bus_if.err_code), 32'd3);
        chk("t2_unlocked", 32'(bus_if.locked), 32'd0);
        chk("t2_sticky", 32'(bus_if.err_sticky), 32'd1);
        run(Y, 5, 0);
        chk("t2_pulse_ends", 32'(bus_if.err_valid), 32'd0);

        // 3) long red: Y->R relocks, then 23 red samples
        pulses = 0;
        run(R, 23, 0);
        chk("t3_one_pulse", 32'(pulses), 32'd1);
        chk("t3_pulse_on_22nd", 32'(pulse_at), 32'd22);
        chk("t3_code_long", 32'(bus_if.err_code), 32'd4);

        // 4) bad sequence, then illegal encoding
        run(G, 16, 0);
        run(Y, 6, 0);
        run(R, 21, 0);
        chk("t4_cycles", 32'(bus_if.cycles), 32'd2);
        cyc(Y, 0);
        chk("t4_code_badseq", 32'(bus_if.err_code), 32'd2);
        pulses = 0;
        run(3'b110, 3, 0);
        chk("t4_illegal_one_pulse", 32'(pulses), 32'd1);
        chk("t4_code_illegal", 32'(bus_if.err_code), 32'd1);
        chk("t4_phase_none", 32'(bus_if.phase), 32'd0);

        // 5) reset mid-green, then a fresh full cycle
        run(R, 21, 0);
        run(G, 5, 0);
        async_reset();
        chk("t5_cycles_cleared", 32'(bus_if.cycles), 32'd0);
        run(R, 21, 0);
        run(G, 16, 0);
        run(Y, 6, 0);
        run(R, 3, 0);
        chk("t5_relocked", 32'(bus_if.locked), 32'd1);
        chk("t5_cycles", 32'(bus_if.cycles), 32'd1);

        // clear coinciding with a new error keeps sticky set
        cyc(Y, 1);
        chk("clr_vs_err_sticky", 32'(bus_if.err_sticky), 32'd1);
        cyc(Y, 1);
        chk("clr_sticky", 32'(bus_if.err_sticky), 32'd0);

        // 6) 300 errors to saturate the optional counter
        for (int i = 0; i < 300; i++) begin
            cyc(3'b011, 0);
            cyc(R, 0);
        end
`ifdef TLM_ERR_CNT_EN
        chk("t6_saturated", 32'(bus_if.err_count), 32'd255);
`else
        chk("t6_count_tied", 32'(bus_if.err_count), 32'd0);
`endif
        cyc(R, 1);
        chk("t6_clr_sticky", 32'(bus_if.err_sticky), 32'd0);
        chk("t6_clr_count", 32'(bus_if.err_count), 32'd0);

        // random phase sequences with occasional faults and clears
        for (int s = 0; s < 150; s++) begin
            cur = bus_if.light;
            k   = $urandom_range(0, 11);
            if (k == 0) begin
                v = bad_vals[$urandom_range(0, 4)];
                n = $urandom_range(1, 3);
            end else begin
                if (pos(cur) < 0)
                    v = R;
                else if (k == 1)
                    v = ring[(pos(cur) + 2) % 3];
                else
                    v = ring[(pos(cur) + 1) % 3];
                off = (k < 9) ? 0 : int'($urandom_range(0, 4)) - 2;
                n   = dur_tab[pos(v)] + off;
            end
            run(v, n, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
